// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared sizing helpers and pixel type for the NPU window datapath
//
// Contents:
//   PIXEL_W            default pixel width used by pixel_t
//   pixel_t            pixel type at the default width
//   clog2_safe()       ceil(log2(n)), never below 1 so 1- and 2-entry ranges still get a bit
//   win_w()            width of a flattened K x K window of BIT_DEPTH pixels
//   windows_per_frame  number of stride-aligned windows in a ROWS x COLS frame
package npu_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int win_w(input int k, input int bit_depth);
    return k * k * bit_depth;
  endfunction

  function automatic int windows_per_frame(input int rows, input int cols,
                                           input int k, input int stride);
    return ((rows - k) / stride + 1) * ((cols - k) / stride + 1);
  endfunction

endpackage

// File: rtl/line_store.sv
// rtl/line_store.sv - K-1 row history of the image, one entry per column
//
// Ports:
//   clk_i   clock
//   we_i    write strobe: shift column col_i up one row and insert din_i at the bottom
//   col_i   column being read and written
//   din_i   incoming pixel (becomes the newest row)
//   rd_o    all K-1 stored rows at column col_i, row i at bits [i*BIT_DEPTH +: BIT_DEPTH],
//           row 0 is the oldest; reflects contents before this cycle's write
module line_store
  import npu_pkg::*;
#(
  parameter  int BIT_DEPTH = 8,
  parameter  int COLS      = 28,
  parameter  int K         = 3,
  localparam int COL_W     = clog2_safe(COLS)
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [COL_W-1:0]             col_i,
  input  logic [BIT_DEPTH-1:0]         din_i,
  output logic [(K-1)*BIT_DEPTH-1:0]   rd_o
);

  // No reset: stale contents are never used because emission waits for K-1 fresh rows.
  logic [BIT_DEPTH-1:0] mem_q [K-1][COLS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < K - 2; i++) begin
        mem_q[i][col_i] <= mem_q[i+1][col_i];
      end
      mem_q[K-2][col_i] <= din_i;
    end
  end

  always_comb begin
    rd_o = '0;
    for (int i = 0; i < K - 1; i++) begin
      rd_o[i*BIT_DEPTH +: BIT_DEPTH] = mem_q[i][col_i];
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - streaming K x K sliding-window generator with stride and backpressure
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   clr         synchronous frame restart (counters and output flags; window data held)
//   in_valid    pixel valid
//   in_ready    pixel accepted when in_valid && in_ready
//   in_data     pixel, raster order
//   out_valid   window valid
//   out_ready   consumer ready
//   out_window  element (i,j) at [(i*K+j)*BIT_DEPTH +: BIT_DEPTH], i=0 top row, j=0 left column
//   out_row     image row of the window's top-left element
//   out_col     image column of the window's top-left element
//   out_last    final window of the frame
module conv_window_buffer
  import npu_pkg::*;
#(
  parameter  int BIT_DEPTH = 8,
  parameter  int COLS      = 28,
  parameter  int ROWS      = 28,
  parameter  int K         = 3,
  parameter  int STRIDE    = 1,
  localparam int WIN_W     = win_w(K, BIT_DEPTH),
  localparam int ROW_W     = clog2_safe(ROWS),
  localparam int COL_W     = clog2_safe(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIN_W-1:0]     out_window,
  output logic [ROW_W-1:0]     out_row,
  output logic [COL_W-1:0]     out_col,
  output logic                 out_last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [WIN_W-1:0] win_q, win_d;

  logic             out_valid_q;
  logic             out_last_q;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;
  logic [WIN_W-1:0] out_window_q;

  logic                       accept;
  logic                       emit;
  logic                       row_ok, col_ok, is_last;
  logic [ROW_W-1:0]           row_off;
  logic [COL_W-1:0]           col_off;
  logic [(K-1)*BIT_DEPTH-1:0] line_rd;

  // Single output register: a pending window only blocks input while it is not being taken.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  line_store #(
    .BIT_DEPTH (BIT_DEPTH),
    .COLS      (COLS),
    .K         (K)
  ) u_line_store (
    .clk_i (clk),
    .we_i  (accept && rst_n && !clr),
    .col_i (col_q),
    .din_i (in_data),
    .rd_o  (line_rd)
  );

  // Window shifts left; the new right column is the stored history above this pixel plus the pixel.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_d[(i*K+j)*BIT_DEPTH +: BIT_DEPTH] = win_q[(i*K+j+1)*BIT_DEPTH +: BIT_DEPTH];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      win_d[(i*K+K-1)*BIT_DEPTH +: BIT_DEPTH] = line_rd[i*BIT_DEPTH +: BIT_DEPTH];
    end
    win_d[((K-1)*K+K-1)*BIT_DEPTH +: BIT_DEPTH] = in_data;
  end

  // Raster position of the next pixel; wraps at frame end so frames can run back-to-back.
  always_comb begin
    row_d = row_q;
    col_d = col_q + 1'b1;
    if (col_q == COL_W'(COLS - 1)) begin
      col_d = '0;
      row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end
  end

  // STRIDE is 1 or 2, so stride alignment reduces to the offset's LSB.
  assign row_off = row_q - ROW_W'(K - 1);
  assign col_off = col_q - COL_W'(K - 1);
  assign row_ok  = (row_q >= ROW_W'(K - 1)) && ((STRIDE == 1) || !row_off[0]);
  assign col_ok  = (col_q >= COL_W'(K - 1)) && ((STRIDE == 1) || !col_off[0]);
  assign is_last = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));
  assign emit    = accept && row_ok && col_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_window_q <= '0;
    end else if (clr) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      if (accept) begin
        row_q <= row_d;
        col_q <= col_d;
        win_q <= win_d;
      end
      if (emit) begin
        out_valid_q  <= 1'b1;
        out_window_q <= win_d;
        out_row_q    <= row_off;
        out_col_q    <= col_off;
        out_last_q   <= is_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb/tb_conv_window_buffer.sv - directed self-checking bench for conv_window_buffer
module tb_conv_window_buffer;
  import npu_pkg::*;

  localparam int BD = 8;
  localparam int NC = 5;
  localparam int NR = 5;
  localparam int KK = 3;
  localparam int WW = KK * KK * BD;
  localparam int RW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  pixel_t        in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_window;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  logic          clr2 = 1'b0;
  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  pixel_t        in_data2 = '0;
  logic          out_valid2;
  logic          out_ready2 = 1'b1;
  logic [WW-1:0] out_window2;
  logic [RW-1:0] out_row2;
  logic [CW-1:0] out_col2;
  logic          out_last2;

  always #5 clk = ~clk;

  conv_window_buffer #(.BIT_DEPTH(BD), .COLS(NC), .ROWS(NR), .K(KK), .STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  conv_window_buffer #(.BIT_DEPTH(BD), .COLS(NC), .ROWS(NR), .K(KK), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_window(out_window2),
    .out_row(out_row2), .out_col(out_col2), .out_last(out_last2)
  );

  typedef struct {
    logic [WW-1:0] win;
    int            row;
    int            col;
    logic          last;
  } rec_t;

  rec_t q1[$];
  rec_t q2[$];
  int   acc_cnt   = 0;
  int   first_acc = -1;
  int   checks    = 0;
  int   errors    = 0;

  // Sampled on the falling edge: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    rec_t r;
    if (out_valid && first_acc < 0) first_acc = acc_cnt;
    if (out_valid && out_ready) begin
      r.win = out_window; r.row = int'(out_row); r.col = int'(out_col); r.last = out_last;
      q1.push_back(r);
    end
    if (in_valid && in_ready) acc_cnt++;
    if (out_valid2 && out_ready2) begin
      r.win = out_window2; r.row = int'(out_row2); r.col = int'(out_col2); r.last = out_last2;
      q2.push_back(r);
    end
  end

  // Pixel at raster position (r,c) of the 5x5 test image is 5r+c+1.
  function automatic logic [WW-1:0] exp_win(input int r0, input int c0);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        w[(i*KK+j)*BD +: BD] = 8'(NC * (r0 + i) + (c0 + j) + 1);
    return w;
  endfunction

  task automatic clear_mon();
    q1.delete();
    q2.delete();
    acc_cnt   = 0;
    first_acc = -1;
  endtask

  task automatic send(input int v);
    int waited;
    in_valid = 1'b1;
    in_data  = 8'(v);
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed %0b for pixel %0d, required 1", in_ready, v);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int first_idx, input int n);
    for (int k = 0; k < n; k++) send(((first_idx + k) % (NR * NC)) + 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    checks++; if (out_row !== '0 || out_col !== '0) begin errors++; $display("FAIL reset_tags: got (%0d,%0d) expected (0,0)", out_row, out_col); end
    checks++; if (out_window !== '0) begin errors++; $display("FAIL reset_window: got %h expected 0", out_window); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_baseline();
    clear_mon();
    send_frame(0, 25);
    settle();
    checks++; if (first_acc !== 13) begin errors++; $display("FAIL base_latency: first window after %0d accepts, expected 13", first_acc); end
    checks++; if (q1.size() !== 9) begin errors++; $display("FAIL base_count: got %0d windows expected 9", q1.size()); end
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      checks++; if (q1[n].win !== exp_win(n / 3, n % 3)) begin errors++; $display("FAIL base_win[%0d]: got %h expected %h", n, q1[n].win, exp_win(n / 3, n % 3)); end
      checks++; if (q1[n].row !== n / 3 || q1[n].col !== n % 3) begin errors++; $display("FAIL base_tag[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, q1[n].row, q1[n].col, n / 3, n % 3); end
      checks++; if (q1[n].last !== (n == 8)) begin errors++; $display("FAIL base_last[%0d]: got %0b expected %0b", n, q1[n].last, n == 8); end
    end
  endtask

  task automatic test_stride2();
    int waited;
    clear_mon();
    for (int idx = 0; idx < 25; idx++) begin
      in_valid2 = 1'b1;
      in_data2  = 8'(idx + 1);
      waited    = 0;
      forever begin
        @(negedge clk);
        if (in_ready2) break;
        waited++;
        if (waited > 50) begin
          checks++; errors++;
          $display("FAIL s2_send_timeout: in_ready2 stayed %0b, required 1", in_ready2);
          break;
        end
      end
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    settle();
    checks++; if (q2.size() !== 4) begin errors++; $display("FAIL s2_count: got %0d windows expected 4", q2.size()); end
    for (int n = 0; n < q2.size() && n < 4; n++) begin
      checks++; if (q2[n].win !== exp_win((n / 2) * 2, (n % 2) * 2)) begin errors++; $display("FAIL s2_win[%0d]: got %h expected %h", n, q2[n].win, exp_win((n / 2) * 2, (n % 2) * 2)); end
      checks++; if (q2[n].row !== (n / 2) * 2 || q2[n].col !== (n % 2) * 2) begin errors++; $display("FAIL s2_tag[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, q2[n].row, q2[n].col, (n / 2) * 2, (n % 2) * 2); end
      checks++; if (q2[n].last !== (n == 3)) begin errors++; $display("FAIL s2_last[%0d]: got %0b expected %0b", n, q2[n].last, n == 3); end
    end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] held_win;
    logic [RW-1:0] held_row;
    logic [CW-1:0] held_col;
    int            waited;
    clear_mon();
    out_ready = 1'b0;
    fork
      send_frame(0, 25);
      begin
        waited = 0;
        while (!out_valid && waited < 100) begin @(negedge clk); waited++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait_valid: out_valid %0b expected 1", out_valid); end
        held_win = out_window; held_row = out_row; held_col = out_col;
        checks++; if (held_win !== exp_win(0, 0)) begin errors++; $display("FAIL bp_first_win: got %h expected %h", held_win, exp_win(0, 0)); end
        repeat (5) begin
          @(negedge clk);
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
          checks++; if (out_window !== held_win || out_row !== held_row || out_col !== held_col) begin errors++; $display("FAIL bp_hold: got %h (%0d,%0d) expected %h (%0d,%0d)", out_window, out_row, out_col, held_win, held_row, held_col); end
          checks++; if (acc_cnt !== 13) begin errors++; $display("FAIL bp_accepts: got %0d accepts expected 13", acc_cnt); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    settle();
    checks++; if (acc_cnt !== 25) begin errors++; $display("FAIL bp_total_accepts: got %0d expected 25", acc_cnt); end
    checks++; if (q1.size() !== 9) begin errors++; $display("FAIL bp_count: got %0d windows expected 9", q1.size()); end
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      checks++; if (q1[n].win !== exp_win(n / 3, n % 3) || q1[n].row !== n / 3 || q1[n].col !== n % 3) begin errors++; $display("FAIL bp_win[%0d]: got %h (%0d,%0d) expected %h (%0d,%0d)", n, q1[n].win, q1[n].row, q1[n].col, exp_win(n / 3, n % 3), n / 3, n % 3); end
      checks++; if (q1[n].last !== (n == 8)) begin errors++; $display("FAIL bp_last[%0d]: got %0b expected %0b", n, q1[n].last, n == 8); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(0, 50);
    settle();
    checks++; if (q1.size() !== 18) begin errors++; $display("FAIL b2b_count: got %0d windows expected 18", q1.size()); end
    for (int n = 0; n < q1.size() && n < 18; n++) begin
      checks++; if (q1[n].win !== exp_win((n % 9) / 3, n % 3) || q1[n].row !== (n % 9) / 3 || q1[n].col !== n % 3) begin errors++; $display("FAIL b2b_win[%0d]: got %h (%0d,%0d) expected %h (%0d,%0d)", n, q1[n].win, q1[n].row, q1[n].col, exp_win((n % 9) / 3, n % 3), (n % 9) / 3, n % 3); end
      checks++; if (q1[n].last !== ((n % 9) == 8)) begin errors++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", n, q1[n].last, (n % 9) == 8); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_frame(0, 17);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
    checks++; if (out_window !== '0) begin errors++; $display("FAIL midrst_window: got %h expected 0", out_window); end
    rst_n = 1'b1;
    clear_mon();
    send_frame(0, 25);
    settle();
    checks++; if (first_acc !== 13) begin errors++; $display("FAIL midrst_latency: first window after %0d accepts, expected 13", first_acc); end
    checks++; if (q1.size() !== 9) begin errors++; $display("FAIL midrst_count: got %0d windows expected 9", q1.size()); end
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      checks++; if (q1[n].win !== exp_win(n / 3, n % 3) || q1[n].row !== n / 3 || q1[n].col !== n % 3 || q1[n].last !== (n == 8)) begin errors++; $display("FAIL midrst_win[%0d]: got %h (%0d,%0d) last %0b expected %h (%0d,%0d) last %0b", n, q1[n].win, q1[n].row, q1[n].col, q1[n].last, exp_win(n / 3, n % 3), n / 3, n % 3, n == 8); end
    end
  endtask

  task automatic test_clr();
    clear_mon();
    send_frame(0, 13);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %0b expected 1", out_valid); end
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd14;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b expected 0", out_valid); end
    checks++; if (out_window !== exp_win(0, 0)) begin errors++; $display("FAIL clr_window_hold: got %h expected %h", out_window, exp_win(0, 0)); end
    checks++; if (out_row !== '0 || out_col !== '0) begin errors++; $display("FAIL clr_tags: got (%0d,%0d) expected (0,0)", out_row, out_col); end
    clear_mon();
    send_frame(0, 25);
    settle();
    checks++; if (first_acc !== 13) begin errors++; $display("FAIL clr_latency: first window after %0d accepts, expected 13", first_acc); end
    checks++; if (q1.size() !== 9) begin errors++; $display("FAIL clr_count: got %0d windows expected 9", q1.size()); end
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      checks++; if (q1[n].win !== exp_win(n / 3, n % 3) || q1[n].row !== n / 3 || q1[n].col !== n % 3 || q1[n].last !== (n == 8)) begin errors++; $display("FAIL clr_win[%0d]: got %h (%0d,%0d) last %0b expected %h (%0d,%0d) last %0b", n, q1[n].win, q1[n].row, q1[n].col, q1[n].last, exp_win(n / 3, n % 3), n / 3, n % 3, n == 8); end
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_stride2();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
